fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO between NREQ producers in the write clock domain. It grants one requester at a time for a burst and muxes that requester's data onto the FIFO write port. It gates every beat with the FIFO full flag. A burst can be capped in length so that no producer starves the others.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data width per requester
MAX_BURST, 8, maximum beats per grant (1..255)
IDW, 2, width of the grant id; must equal clog2(NREQ)

Ports:
wr_clk  in  1  write-domain clock
wr_rst  in  1  asynchronous active-low reset
req  in  NREQ  per-requester write request; bit i belongs to requester i
data  in  NREQ*DW  packed write data; requester i occupies data[i*DW +: DW]
last  in  NREQ  marks the final beat of requester i's burst
ready  out  NREQ  beat accepted from requester i this cycle when req[i] & ready[i]
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  DW  FIFO write data
fifo_full  in  1  FIFO full flag (registered, write domain)
gnt_id  out  IDW  current owner index; valid when busy=1
busy  out  1  1 while in GRANT state

Behaviour:
- Reset is asynchronous and active-low. wr_clk is the only clock. While wr_rst=0: state=IDLE, gnt_id=0, busy=0, beat_cnt=0, last_winner=NREQ-1 (requester 0 wins first). ready, fifo_wr_en and fifo_wr_data are all 0.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - ready=0 and fifo_wr_en=0.
  - If |req, register a winner: the first set req bit scanning upward from (last_winner+1) mod NREQ, wrapping around.
  - Next cycle: state=GRANT, gnt_id=winner, last_winner=winner, beat_cnt=0, busy=1.
  - No req means stay in IDLE.
- GRANT (owner o=gnt_id):
  - Combinational outputs: ready[o]=!fifo_full; ready[j≠o]=0; fifo_wr_en=req[o] & !fifo_full; fifo_wr_data=data[o].
  - In IDLE, fifo_wr_data=0.
  - A beat is accepted when fifo_wr_en=1. On each accepted beat, beat_cnt increments by 1 (8-bit counter, saturating never needed).
  - The burst ends and the FSM returns to IDLE on the next edge when any of these holds:
    - (a) an accepted beat has last[o]=1;
    - (b) an accepted beat makes beat_cnt+1 == MAX_BURST;
    - (c) req[o]=0, meaning the owner abandoned the grant. This also applies while fifo_full=1.
- Arbitration latency: 1 cycle from req to grant. Every burst is followed by exactly one IDLE bubble cycle before re-arbitration.
- fifo_full=1 during GRANT stalls: no beat, no counter change, state held. Beats resume the cycle after full deasserts.
- Requests that arrive during another requester's grant wait. They are served in round-robin order after the current burst.
- If the owner's req and last are held while fifo_full=1, nothing is written.
- Ownership is never lost on a full stall; only conditions (a), (b) or (c) release it.
- Changing a non-owner's req has no effect mid-burst.
- Reset asserted mid-burst: outputs drop to 0 immediately (asynchronous) and the FSM goes to IDLE. Any partially written burst stays in the FIFO; the arbiter does no cleanup.
- Data is not registered, so the requester must hold data[o] stable while req[o]=1 and ready[o]=0.

Test Plan:
- Reset then req=4'b0001, last on beat 3 → gnt_id=0 one cycle after req; fifo_wr_en high 3 cycles with data 0x11, 0x12, 0x13; busy falls after the third beat; one IDLE cycle follows.
- req=4'b1111 held, each requester sends one-beat bursts with last=1 → grant order 0,1,2,3,0; each grant is 2 cycles (GRANT + IDLE); no requester is granted twice before all others.
- Requester 2 alone, last never asserted, MAX_BURST=8 → exactly 8 beats written, then release. With req still high, it is re-granted after one IDLE cycle.
- Requester 1 granted; fifo_full=1 for 5 cycles after beat 2 → ready[1]=0 and fifo_wr_en=0 for those 5 cycles; gnt_id stays 1; beat 3 is written the cycle after full=0; total beats are unchanged.
- Requester 3 granted, drops req after 1 beat with no last → return to IDLE next edge. A pending req[0] is granted after the bubble, because round-robin wraps from 3 to 0.
- Assert wr_rst=0 asynchronously mid-burst, between clock edges → busy, ready and fifo_wr_en go to 0 immediately. After release, the first grant goes to the lowest set req bit starting at index 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ producers.
// Grants a requester for a burst, muxes its data, and gates each beat with fifo_full.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned IDW       = 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   data,
    input  logic [NREQ-1:0]      last,
    output logic [NREQ-1:0]      ready,
    output logic                 fifo_wr_en,
    output logic [DW-1:0]        fifo_wr_data,
    input  logic                 fifo_full,
    output logic [IDW-1:0]       gnt_id,
    output logic                 busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] gnt_id_n;
    logic [IDW-1:0] last_winner, last_winner_n;
    logic [IDW-1:0] winner;
    logic           found;
    logic [7:0]     beat_cnt, beat_cnt_n;
    logic           beat;

    // Scan upward from the slot after the previous winner, wrapping at NREQ.
    always_comb begin
        int unsigned s;
        winner = '0;
        found  = 1'b0;
        s      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            s = 32'(last_winner) + k;
            if (s >= NREQ) s = s - NREQ;
            if (!found && req[IDW'(s)]) begin
                winner = IDW'(s);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n       = state;
        gnt_id_n      = gnt_id;
        last_winner_n = last_winner;
        beat_cnt_n    = beat_cnt;
        ready         = '0;
        fifo_wr_en    = 1'b0;
        fifo_wr_data  = '0;
        beat          = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n       = GRANT;
                    gnt_id_n      = winner;
                    last_winner_n = winner;
                    beat_cnt_n    = '0;
                end
            end
            GRANT: begin
                ready[gnt_id] = !fifo_full;
                beat          = req[gnt_id] & !fifo_full;
                fifo_wr_en    = beat;
                fifo_wr_data  = data[gnt_id*DW +: DW];
                if (beat) beat_cnt_n = beat_cnt + 8'd1;
                // Abandon releases even during a full stall; last/cap only on an accepted beat.
                if (!req[gnt_id] || (beat && (last[gnt_id] || beat_cnt_n == 8'(MAX_BURST))))
                    state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state       <= IDLE;
            gnt_id      <= '0;
            last_winner <= IDW'(NREQ - 1);
            beat_cnt    <= '0;
        end else begin
            state       <= state_n;
            gnt_id      <= gnt_id_n;
            last_winner <= last_winner_n;
            beat_cnt    <= beat_cnt_n;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 8;
    localparam int IDW       = 2;

    logic                wr_clk = 1'b0;
    logic                wr_rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  data;
    logic [NREQ-1:0]     last;
    logic [NREQ-1:0]     ready;
    logic                fifo_wr_en;
    logic [DW-1:0]       fifo_wr_data;
    logic                fifo_full;
    logic [IDW-1:0]      gnt_id;
    logic                busy;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .IDW(IDW)) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .req(req), .data(data), .last(last),
        .ready(ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .gnt_id(gnt_id), .busy(busy)
    );

    always #5 wr_clk = ~wr_clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: who owns the port, who won last, beats in current burst
    bit m_busy;
    int m_owner, m_lw, m_cnt, m_writes;

    // producers
    int            p_len[NREQ];
    logic [DW-1:0] p_data[NREQ];
    bit            p_uselast[NREQ];
    bit            p_lastall[NREQ];
    logic          full_in;

    // observations taken from the DUT
    int wlog[$];
    int wtime[$];
    int glog[$];
    int scen_t;
    bit prev_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wlog.delete(); wtime.delete(); glog.delete();
        scen_t = 0; prev_busy = 0;
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_lw = NREQ - 1; m_cnt = 0; m_writes = 0;
        for (int i = 0; i < NREQ; i++) begin
            p_len[i] = 0; p_data[i] = '0; p_uselast[i] = 0; p_lastall[i] = 0;
        end
        full_in = 1'b0;
    endtask

    task automatic cycle();
        logic [NREQ-1:0] e_ready;
        logic            e_en;
        logic [DW-1:0]   e_data;
        bit              found;
        for (int i = 0; i < NREQ; i++) begin
            req[i]             = (p_len[i] > 0);
            data[i*DW +: DW]   = p_data[i];
            last[i]            = p_lastall[i] || (p_uselast[i] && p_len[i] == 1);
        end
        fifo_full = full_in;
        #1;
        e_ready = '0; e_en = 1'b0; e_data = '0;
        if (m_busy) begin
            e_data = p_data[m_owner];
            if (!full_in) e_ready[m_owner] = 1'b1;
            e_en = req[m_owner] && !full_in;
        end
        chk("busy", 64'(busy), 64'(m_busy));
        chk("ready", 64'(ready), 64'(e_ready));
        chk("fifo_wr_en", 64'(fifo_wr_en), 64'(e_en));
        chk("fifo_wr_data", 64'(fifo_wr_data), 64'(e_data));
        if (m_busy) chk("gnt_id", 64'(gnt_id), 64'(m_owner));
        if (fifo_wr_en === 1'b1) begin
            wlog.push_back(int'(fifo_wr_data));
            wtime.push_back(scen_t);
        end
        if (busy === 1'b1 && !prev_busy) glog.push_back(int'(gnt_id));
        prev_busy = (busy === 1'b1);

        if (!m_busy) begin
            if (req != '0) begin
                found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    int i;
                    i = (m_lw + k) % NREQ;
                    if (!found && req[i]) begin
                        m_owner = i;
                        found = 1;
                    end
                end
                m_lw = m_owner; m_busy = 1; m_cnt = 0;
            end
        end else if (!req[m_owner]) begin
            m_busy = 0;
        end else if (!full_in) begin
            m_cnt++; m_writes++;
            p_len[m_owner]--;
            p_data[m_owner]++;
            if (last[m_owner] || m_cnt == MAX_BURST) m_busy = 0;
        end
        @(posedge wr_clk);
        @(negedge wr_clk);
        scen_t++;
    endtask

    task automatic do_reset();
        wr_rst = 1'b0;
        model_reset();
        req = '0; data = '0; last = '0; fifo_full = 1'b0;
        @(posedge wr_clk);
        @(negedge wr_clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gnt_id", 64'(gnt_id), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst_wr_data", 64'(fifo_wr_data), 64'd0);
        wr_rst = 1'b1;
        clear_logs();
    endtask

    initial begin
        // single requester, three beats ending on last
        do_reset();
        p_len[0] = 3; p_data[0] = 8'h11; p_uselast[0] = 1;
        repeat (6) cycle();
        chk("A_grants", 64'(glog.size()), 64'd1);
        chk("A_gnt0", 64'(glog[0]), 64'd0);
        chk("A_beats", 64'(wlog.size()), 64'd3);
        chk("A_d0", 64'(wlog[0]), 64'h11);
        chk("A_d2", 64'(wlog[2]), 64'h13);
        chk("A_t0", 64'(wtime[0]), 64'd1);
        chk("A_t2", 64'(wtime[2]), 64'd3);

        // all four requesting, one-beat bursts
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            p_len[i] = 3; p_data[i] = 8'(8'hA0 + 8'h10 * i); p_lastall[i] = 1;
        end
        repeat (10) cycle();
        chk("B_grants", 64'(glog.size()), 64'd5);
        for (int g = 0; g < 5; g++) begin
            chk("B_order", 64'(glog[g]), 64'(g % NREQ));
            chk("B_time", 64'(wtime[g]), 64'(2 * g + 1));
        end
        chk("B_d4", 64'(wlog[4]), 64'hA1);

        // burst capped at MAX_BURST, then re-granted after one bubble
        do_reset();
        p_len[2] = 20; p_data[2] = 8'h40;
        repeat (14) cycle();
        chk("C_grants", 64'(glog.size()), 64'd2);
        chk("C_gnt0", 64'(glog[0]), 64'd2);
        chk("C_gnt1", 64'(glog[1]), 64'd2);
        chk("C_beats", 64'(wlog.size()), 64'd12);
        chk("C_t7", 64'(wtime[7]), 64'd8);
        chk("C_t8", 64'(wtime[8]), 64'd10);
        chk("C_d8", 64'(wlog[8]), 64'h48);

        // full stall after beat 2 for five cycles
        do_reset();
        p_len[1] = 5; p_data[1] = 8'h60; p_uselast[1] = 1;
        for (int t = 0; t < 12; t++) begin
            full_in = (t >= 3 && t <= 7);
            cycle();
        end
        chk("D_grants", 64'(glog.size()), 64'd1);
        chk("D_gnt", 64'(glog[0]), 64'd1);
        chk("D_beats", 64'(wlog.size()), 64'd5);
        chk("D_t1", 64'(wtime[1]), 64'd2);
        chk("D_t2", 64'(wtime[2]), 64'd8);
        chk("D_t4", 64'(wtime[4]), 64'd10);
        chk("D_d2", 64'(wlog[2]), 64'h62);

        // owner 3 abandons, pending 0 wins after the bubble
        do_reset();
        p_len[3] = 1; p_data[3] = 8'h70;
        cycle();
        p_len[0] = 1; p_data[0] = 8'h80; p_uselast[0] = 1;
        repeat (6) cycle();
        chk("E_grants", 64'(glog.size()), 64'd2);
        chk("E_gnt0", 64'(glog[0]), 64'd3);
        chk("E_gnt1", 64'(glog[1]), 64'd0);
        chk("E_beats", 64'(wlog.size()), 64'd2);
        chk("E_d1", 64'(wlog[1]), 64'h80);
        chk("E_t1", 64'(wtime[1]), 64'd4);

        // asynchronous reset mid-burst
        do_reset();
        p_len[2] = 10; p_data[2] = 8'h90;
        repeat (3) cycle();
        chk("F_busy_before", 64'(busy), 64'd1);
        #2 wr_rst = 1'b0;
        #1;
        chk("F_busy", 64'(busy), 64'd0);
        chk("F_ready", 64'(ready), 64'd0);
        chk("F_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("F_wr_data", 64'(fifo_wr_data), 64'd0);
        model_reset();
        for (int i = 1; i < NREQ; i++) begin
            p_len[i] = 2; p_data[i] = 8'(8'hC0 + i); p_uselast[i] = 1;
        end
        @(negedge wr_clk);
        wr_rst = 1'b1;
        clear_logs();
        repeat (4) cycle();
        chk("F_first_gnt", 64'(glog[0]), 64'd1);

        // randomized traffic with random full and occasional abandon
        do_reset();
        repeat (600) begin
            for (int i = 0; i < NREQ; i++) begin
                if (p_len[i] == 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        p_len[i]     = int'($urandom_range(1, 12));
                        p_uselast[i] = ($urandom_range(0, 1) == 1);
                        p_lastall[i] = ($urandom_range(0, 7) == 0);
                        p_data[i]    = DW'($urandom);
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    p_len[i] = 0;
                end
            end
            full_in = ($urandom_range(0, 2) == 0);
            cycle();
        end
        chk("R_write_count", 64'(wlog.size()), 64'(m_writes));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
